chunked_cpa_seq: RTL and testbench

- Parametrised multi-cycle carry-propagate adder/subtractor. It is the sequential successor of the team's 4-bit ripple CPA.
- Operands are WIDTH bits wide. Each clock it processes one CHUNK-bit slice through a combinational ripple full-adder chain, and the carry is registered between slices.
- It uses a start/done handshake and provides add or subtract mode plus carry, overflow and zero flags.
- It sits between operand registers (DIP/switch inputs in the bench) and result consumers (LEDs, datapath registers).

---
 rtl/cpa_pkg.sv | 19 +
 rtl/chunked_cpa_seq_if.sv | 27 ++
 rtl/cpa_chunk.sv | 24 ++
 rtl/chunked_cpa_seq.sv | 115 +++++++++++
 tb/tb_chunked_cpa_seq.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpa_pkg.sv
// Shared definitions for the chunked carry-propagate adder: FSM state codes,
// operation mode codes and a parameter sanity helper.
package cpa_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // A chunk must tile the operand exactly; checked at elaboration by the top.
  function automatic bit cfg_ok(int width, int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunked_cpa_seq_if.sv
// Request/result bundle of the chunked adder: operands and start from the
// requester, registered result and status back to it.
interface chunked_cpa_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, A, B, Cin,
    input  busy, done, S, Cout, ovf, zero
  );

  modport slave (
    input  start, mode, A, B, Cin,
    output busy, done, S, Cout, ovf, zero
  );
endinterface

// File: rtl/cpa_chunk.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
// Zero latency; no handshake, purely combinational.
module cpa_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] S,
  output logic         Cout
);

  logic [W:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[W];

endmodule

// File: rtl/chunked_cpa_seq.sv
// Multi-cycle add/subtract, one CHUNK slice per clock; done in cycle NCHUNK+1
// after the accepting edge. start is only honoured in IDLE/DONE, ignored in RUN.
module chunked_cpa_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  chunked_cpa_seq_if.slave   bus
);

  import cpa_pkg::*;

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("chunked_cpa_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [WIDTH-1:0] b_eff;
  logic [CHUNK-1:0] slice;
  logic             slice_co;
  logic [WIDTH-1:0] next_acc;
  logic             last;

  assign b_eff = (bus.mode == MODE_SUB) ? ~bus.B : bus.B;
  assign last  = (cnt == CW'(NCHUNK - 1));

  // Operands shift right each cycle so the adder always sees bits [CHUNK-1:0];
  // finished slices enter the accumulator from the top.
  cpa_chunk #(.W(CHUNK)) u_chunk (
    .A    (a_q[CHUNK-1:0]),
    .B    (b_q[CHUNK-1:0]),
    .Cin  (carry_q),
    .S    (slice),
    .Cout (slice_co)
  );

  always_comb begin
    next_acc = (acc >> CHUNK) | (WIDTH'(slice) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= b_eff;
            carry_q <= (bus.mode == MODE_SUB) ? 1'b1 : bus.Cin;
            a_msb_q <= bus.A[WIDTH-1];
            b_msb_q <= b_eff[WIDTH-1];
            cnt     <= '0;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          acc     <= next_acc;
          carry_q <= slice_co;
          if (last) begin
            // Results are published together on the final slice edge only.
            cnt    <= '0;
            state  <= DONE;
            s_q    <= next_acc;
            cout_q <= slice_co;
            ovf_q  <= (a_msb_q == b_msb_q) && (next_acc[WIDTH-1] != a_msb_q);
            zero_q <= (next_acc == '0);
          end else begin
            cnt    <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_chunked_cpa_seq.sv
// Bench for chunked_cpa_seq: three configurations (16/4, 16/16, 8/2) share one
// stimulus bus; each check looks at the instance under test.
module tb_chunked_cpa_seq;

  import cpa_pkg::*;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        mode_i;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        cin_i;

  int tests = 0;
  int fails = 0;

  chunked_cpa_seq_if #(.WIDTH(16)) if0 ();
  chunked_cpa_seq_if #(.WIDTH(16)) if1 ();
  chunked_cpa_seq_if #(.WIDTH(8))  if2 ();

  assign if0.start = start_i;
  assign if0.mode  = mode_i;
  assign if0.A     = a_i;
  assign if0.B     = b_i;
  assign if0.Cin   = cin_i;
  assign if1.start = start_i;
  assign if1.mode  = mode_i;
  assign if1.A     = a_i;
  assign if1.B     = b_i;
  assign if1.Cin   = cin_i;
  assign if2.start = start_i;
  assign if2.mode  = mode_i;
  assign if2.A     = a_i[7:0];
  assign if2.B     = b_i[7:0];
  assign if2.Cin   = cin_i;

  chunked_cpa_seq #(.WIDTH(16), .CHUNK(4))  dut0 (.clk(clk), .rst(rst), .bus(if0));
  chunked_cpa_seq #(.WIDTH(16), .CHUNK(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  chunked_cpa_seq #(.WIDTH(8),  .CHUNK(2))  dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [15:0] s_o    [3];
  logic        busy_o [3];
  logic        done_o [3];
  logic        cout_o [3];
  logic        ovf_o  [3];
  logic        zero_o [3];

  assign s_o[0] = if0.S;
  assign s_o[1] = if1.S;
  assign s_o[2] = {8'h00, if2.S};
  assign busy_o[0] = if0.busy;
  assign busy_o[1] = if1.busy;
  assign busy_o[2] = if2.busy;
  assign done_o[0] = if0.done;
  assign done_o[1] = if1.done;
  assign done_o[2] = if2.done;
  assign cout_o[0] = if0.Cout;
  assign cout_o[1] = if1.Cout;
  assign cout_o[2] = if2.Cout;
  assign ovf_o[0]  = if0.ovf;
  assign ovf_o[1]  = if1.ovf;
  assign ovf_o[2]  = if2.ovf;
  assign zero_o[0] = if0.zero;
  assign zero_o[1] = if1.zero;
  assign zero_o[2] = if2.zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ncyc(int cfg);
    return (cfg == 1) ? 1 : 4;
  endfunction

  function automatic int wid(int cfg);
    return (cfg == 2) ? 8 : 16;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from the true signed result.
  task automatic ref_op(input int w, input bit m, input int a, input int b, input bit cin,
                        output int s, output bit co, output bit ov, output bit z);
    int half, full, sa, sb, sres;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    if (m == MODE_ADD) begin
      full = a + b + int'(cin);
      sres = sa + sb + int'(cin);
      co   = (full >= (1 << w));
    end else begin
      full = a - b;
      sres = sa - sb;
      co   = (a >= b);
    end
    s  = full & ((1 << w) - 1);
    ov = (sres > half - 1) || (sres < -half);
    z  = (s == 0);
  endtask

  // One operation: start for one edge, scramble inputs afterwards, track busy/done.
  task automatic do_op(input int cfg, input bit m, input logic [15:0] a, input logic [15:0] b,
                       input bit cin, output logic [15:0] s, output logic co,
                       output logic ov, output logic z, output int dc);
    int n, c;
    bit bad;
    n = ncyc(cfg);
    bad = 0;
    dc = 0;
    c = 0;
    s = '0; co = 0; ov = 0; z = 0;
    mode_i = m; a_i = a; b_i = b; cin_i = cin; start_i = 1'b1;
    while (dc == 0 && c < n + 3) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) begin
        start_i = 1'b0;
        a_i = 16'($urandom);
        b_i = 16'($urandom);
        cin_i = 1'($urandom);
        mode_i = 1'($urandom);
      end
      if (busy_o[cfg] !== (c <= n)) bad = 1;
      if (done_o[cfg] === 1'b1) begin
        dc = c;
        s = s_o[cfg]; co = cout_o[cfg]; ov = ovf_o[cfg]; z = zero_o[cfg];
      end
    end
    chk("done latency", dc, n + 1);
    chk("busy window", {31'd0, bad}, 0);
  endtask

  function automatic int pick(int w);
    int mask, sel;
    mask = (1 << w) - 1;
    sel = int'($urandom_range(0, 11));
    case (sel)
      0: return 0;
      1: return mask;
      2: return 1 << (w - 1);
      3: return (1 << (w - 1)) - 1;
      default: return int'($urandom) & mask;
    endcase
  endfunction

  typedef struct {
    bit          m;
    logic [15:0] a;
    logic [15:0] b;
    bit          cin;
    logic [15:0] s;
    bit          co;
    bit          ov;
    bit          z;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [15:0] rs;
    logic rco, rov, rz;
    int dc, d1, d2, es, bad;
    bit eco, eov, ez;

    tbl[0] = '{MODE_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{MODE_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{MODE_SUB, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{MODE_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{MODE_ADD, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{MODE_SUB, 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{MODE_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; start_i = 1'b1; mode_i = 1'b0; a_i = 16'h1234; b_i = 16'h1111; cin_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset busy", {31'd0, busy_o[k]}, 0);
      chk("reset done", {31'd0, done_o[k]}, 0);
      chk("reset S", {16'd0, s_o[k]}, 0);
      chk("reset flags", {29'd0, cout_o[k], ovf_o[k], zero_o[k]}, 0);
    end
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;

    // Directed vectors on the chunked and the single-cycle configurations.
    for (int cfg = 0; cfg < 2; cfg++) begin
      for (int i = 0; i < 8; i++) begin
        do_op(cfg, tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].cin, rs, rco, rov, rz, dc);
        chk("vec S", {16'd0, rs}, {16'd0, tbl[i].s});
        chk("vec Cout", {31'd0, rco}, {31'd0, tbl[i].co});
        chk("vec ovf", {31'd0, rov}, {31'd0, tbl[i].ov});
        chk("vec zero", {31'd0, rz}, {31'd0, tbl[i].z});
      end
      start_i = 1'b0;
      repeat (6) @(posedge clk);
      #1;
    end

    // start re-pulsed during RUN is ignored and not queued.
    mode_i = MODE_ADD; a_i = 16'h00FF; b_i = 16'h0001; cin_i = 1'b0; start_i = 1'b1;
    dc = 0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 1) start_i = 1'b0;
      if (c == 2) begin start_i = 1'b1; a_i = 16'h1111; b_i = 16'h2222; end
      if (c == 3) start_i = 1'b0;
      if (done_o[0] === 1'b1 && dc == 0) begin
        dc = c;
        chk("repulse S", {16'd0, s_o[0]}, 32'h0100);
      end
      if (c == 7) begin
        chk("repulse not queued", {30'd0, busy_o[0], done_o[0]}, 0);
        chk("result hold", {16'd0, s_o[0]}, 32'h0100);
      end
    end
    chk("repulse done cycle", dc, 5);
    repeat (3) @(posedge clk);
    #1;

    // start held in the done cycle gives back-to-back operation.
    mode_i = MODE_ADD; a_i = 16'h1000; b_i = 16'h0234; cin_i = 1'b0; start_i = 1'b1;
    d1 = 0; d2 = 0; bad = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) start_i = 1'b0;
      if (c == 5) begin start_i = 1'b1; a_i = 16'h0FFF; b_i = 16'h0001; cin_i = 1'b0; end
      if (c == 6) start_i = 1'b0;
      if (done_o[0] === 1'b1) begin
        if (d1 == 0) begin
          d1 = c;
          chk("b2b first S", {16'd0, s_o[0]}, 32'h1234);
        end else if (d2 == 0) begin
          d2 = c;
          chk("b2b second S", {16'd0, s_o[0]}, 32'h1000);
        end
      end
      if (c >= 6 && c <= 9 && busy_o[0] !== 1'b1) bad = 1;
    end
    chk("b2b first done", d1, 5);
    chk("b2b second done", d2, 10);
    chk("b2b busy", bad, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-operation clears outputs and kills the operation.
    mode_i = MODE_ADD; a_i = 16'h0F0F; b_i = 16'h1111; cin_i = 1'b0; start_i = 1'b1;
    bad = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) start_i = 1'b0;
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        rst = 1'b0;
        chk("midrst busy", {31'd0, busy_o[0]}, 0);
        chk("midrst S", {16'd0, s_o[0]}, 0);
        chk("midrst flags", {29'd0, cout_o[0], ovf_o[0], zero_o[0]}, 0);
      end
      if (done_o[0] !== 1'b0) bad = 1;
    end
    chk("midrst no done", bad, 0);

    // Randomised operations against the reference model, all three configurations.
    for (int cfg = 0; cfg < 3; cfg++) begin
      for (int i = 0; i < 1000; i++) begin
        int w, a, b;
        bit m, cin;
        w = wid(cfg);
        a = pick(w);
        b = pick(w);
        m = 1'($urandom);
        cin = 1'($urandom);
        ref_op(w, m, a, b, cin, es, eco, eov, ez);
        do_op(cfg, m, 16'(a), 16'(b), cin, rs, rco, rov, rz, dc);
        chk("rand S", {16'd0, rs}, es);
        chk("rand Cout", {31'd0, rco}, {31'd0, eco});
        chk("rand ovf", {31'd0, rov}, {31'd0, eov});
        chk("rand zero", {31'd0, rz}, {31'd0, ez});
      end
      start_i = 1'b0;
      repeat (6) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
